// File: rtl/serial_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_framer
//  Purpose  : Fibre-link serial transmitter. Snapshots N_CH payload words and
//             sends them MSB first as SYNC | HDR | words | CRC-8 | idle gap,
//             with a per-frame sequence number, SFP-fault abort/recovery,
//             LVDS/SFP driver enables and stretched activity/fault LEDs.
//  Revision : 1.0  initial release
// ============================================================================
module serial_tx_framer #(
    parameter int         N_CH        = 2,
    parameter int         DATA_W      = 16,
    parameter int         BIT_CLKS    = 4,
    parameter int         GAP_BITS    = 4,
    parameter logic [7:0] SYNC_PAT    = 8'hAB,
    parameter int         LED_STRETCH = 400000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_tx_en,
    input  logic                     i_sfp_tx_flt,
    input  logic [N_CH*DATA_W-1:0]   i_tx_data,
    output logic                     o_serial,
    output logic                     o_drv_en,
    output logic                     o_sfp_tx_dis_n,
    output logic                     o_frame_start,
    output logic                     o_busy,
    output logic [3:0]               o_seq,
    output logic [1:0]               o_tx_led
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_PAY_BITS  = N_CH * DATA_W;
    localparam int c_MAX_FIELD = (c_PAY_BITS > GAP_BITS) ? c_PAY_BITS : GAP_BITS;
    localparam int c_IDX_W     = $clog2(c_MAX_FIELD + 1);
    localparam int c_BCLK_W    = $clog2(BIT_CLKS);
    localparam int c_LED_W     = $clog2(LED_STRETCH + 1);

    localparam logic [c_IDX_W-1:0]  c_IDX_ONE    = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0]  c_IDX_BYTE   = c_IDX_W'(7);
    localparam logic [c_IDX_W-1:0]  c_IDX_PAY    = c_IDX_W'(c_PAY_BITS - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_GAP    = c_IDX_W'(GAP_BITS - 1);
    localparam logic [c_BCLK_W-1:0] c_BCLK_ONE   = c_BCLK_W'(1);
    localparam logic [c_BCLK_W-1:0] c_BCLK_LAST  = c_BCLK_W'(BIT_CLKS - 1);
    localparam logic [c_LED_W-1:0]  c_LED_LOAD   = c_LED_W'(LED_STRETCH);
    localparam logic [c_LED_W-1:0]  c_LED_ONE    = c_LED_W'(1);
    localparam logic [3:0]          c_CLR_LAST   = 4'd15;
    localparam logic [7:0]          c_CRC_POLY   = 8'h07;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_HDR   = 3'd2,
        ST_DATA  = 3'd3,
        ST_CRC   = 3'd4,
        ST_GAP   = 3'd5,
        ST_FAULT = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_flt_meta;
    logic                   r_flt_sync;
    logic [3:0]             r_clr_cnt;

    logic [c_BCLK_W-1:0]    r_bit_clk;
    logic [c_IDX_W-1:0]     r_bit_idx;
    logic [c_IDX_W-1:0]     w_idx_last;
    logic                   w_bit_last;
    logic                   w_field_last;
    logic                   w_in_frame;
    logic                   w_busy_nxt;
    logic [2:0]             w_byte_sel;

    logic [c_PAY_BITS-1:0]  w_pay_ordered;
    logic [c_PAY_BITS-1:0]  r_pay;
    logic [7:0]             r_hdr;
    logic [7:0]             r_crc;
    logic [3:0]             r_seq_nxt;
    logic                   w_cur_bit;
    logic                   w_snap;
    logic                   w_fault_entry;

    logic [c_LED_W-1:0]     r_led_act_cnt;
    logic [c_LED_W-1:0]     r_led_flt_cnt;

    // One CRC-8 (poly 0x07, MSB first) step for a single launched bit.
    function automatic logic [7:0] f_crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? c_CRC_POLY : 8'h00);
    endfunction

    // Reorder the payload so word 0 sits in the top bits: the shift register
    // then always launches its MSB and word 0 goes out first.
    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_pay_order
            assign w_pay_ordered[(N_CH-1-g)*DATA_W +: DATA_W] = i_tx_data[g*DATA_W +: DATA_W];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Bit timing helpers
    // ------------------------------------------------------------------------
    assign w_in_frame   = (r_state != ST_IDLE) && (r_state != ST_FAULT);
    assign w_bit_last   = (r_bit_clk == c_BCLK_LAST);
    assign w_field_last = w_bit_last && (r_bit_idx == w_idx_last);
    assign w_byte_sel   = ~r_bit_idx[2:0];

    // Index of the final bit of the field currently being sent.
    always_comb begin
        w_idx_last = c_IDX_BYTE;
        case (r_state)
            ST_DATA: w_idx_last = c_IDX_PAY;
            ST_GAP:  w_idx_last = c_IDX_GAP;
            default: w_idx_last = c_IDX_BYTE;
        endcase
    end

    // Bit value that belongs on the line for the current state and position.
    always_comb begin
        w_cur_bit = 1'b1;
        case (r_state)
            ST_SYNC: w_cur_bit = SYNC_PAT[w_byte_sel];
            ST_HDR:  w_cur_bit = r_hdr[w_byte_sel];
            ST_DATA: w_cur_bit = r_pay[c_PAY_BITS-1];
            ST_CRC:  w_cur_bit = r_crc[w_byte_sel];
            default: w_cur_bit = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Fault synchroniser (2 flops) and fault-clear qualification counter
    // ------------------------------------------------------------------------
    // Bring the asynchronous SFP fault into the clock domain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flt_meta <= 1'b0;
            r_flt_sync <= 1'b0;
        end else begin
            r_flt_meta <= i_sfp_tx_flt;
            r_flt_sync <= r_flt_meta;
        end
    end

    // Count consecutive fault-free clocks while parked in FAULT.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clr_cnt <= 4'd0;
        end else if ((r_state != ST_FAULT) || r_flt_sync) begin
            r_clr_cnt <= 4'd0;
        end else if (r_clr_cnt != c_CLR_LAST) begin
            r_clr_cnt <= r_clr_cnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a synchronised fault overrides everything.
    always_comb begin
        w_state_nxt   = r_state;
        w_snap        = 1'b0;
        w_fault_entry = 1'b0;
        w_busy_nxt    = 1'b0;
        if (r_flt_sync) begin
            w_state_nxt = ST_FAULT;
        end else begin
            case (r_state)
                ST_IDLE:  if (i_tx_en)      w_state_nxt = ST_SYNC;
                ST_SYNC:  if (w_field_last) w_state_nxt = ST_HDR;
                ST_HDR:   if (w_field_last) w_state_nxt = ST_DATA;
                ST_DATA:  if (w_field_last) w_state_nxt = ST_CRC;
                ST_CRC:   if (w_field_last) w_state_nxt = ST_GAP;
                ST_GAP:   if (w_field_last) w_state_nxt = i_tx_en ? ST_SYNC : ST_IDLE;
                ST_FAULT: if (r_clr_cnt == c_CLR_LAST) w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
        w_snap        = (w_state_nxt == ST_SYNC) &&
                        ((r_state == ST_IDLE) || (r_state == ST_GAP));
        w_fault_entry = (w_state_nxt == ST_FAULT) && (r_state != ST_FAULT);
        w_busy_nxt    = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_FAULT);
    end

    // Bit-clock and bit-index counters; both restart on every state change.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bit_clk <= '0;
            r_bit_idx <= '0;
        end else if (!w_in_frame || (w_state_nxt != r_state)) begin
            r_bit_clk <= '0;
            r_bit_idx <= '0;
        end else if (w_bit_last) begin
            r_bit_clk <= '0;
            r_bit_idx <= r_bit_idx + c_IDX_ONE;
        end else begin
            r_bit_clk <= r_bit_clk + c_BCLK_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Snapshot, sequence number, payload shifter and CRC
    // ------------------------------------------------------------------------
    // The header fault flag is the first synchroniser stage: a fault that is
    // arriving but not yet qualified gets flagged in the frame it aborts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pay     <= '0;
            r_hdr     <= 8'h00;
            r_crc     <= 8'h00;
            r_seq_nxt <= 4'd0;
            o_seq     <= 4'd0;
        end else if (w_snap) begin
            r_pay     <= w_pay_ordered;
            r_hdr     <= {r_seq_nxt, r_flt_meta, 3'b000};
            r_crc     <= 8'h00;
            o_seq     <= r_seq_nxt;
            r_seq_nxt <= r_seq_nxt + 4'd1;
        end else begin
            if (((r_state == ST_HDR) || (r_state == ST_DATA)) && (r_bit_clk == '0)) begin
                r_crc <= f_crc8_step(r_crc, w_cur_bit);
            end
            if ((r_state == ST_DATA) && w_bit_last) begin
                r_pay <= r_pay << 1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered line and status outputs
    // ------------------------------------------------------------------------
    // The line is forced idle on the same edge that enters FAULT.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_serial       <= 1'b1;
            o_frame_start  <= 1'b0;
            o_busy         <= 1'b0;
            o_drv_en       <= 1'b0;
            o_sfp_tx_dis_n <= 1'b0;
        end else begin
            o_serial       <= r_flt_sync ? 1'b1 : w_cur_bit;
            o_frame_start  <= w_snap;
            o_busy         <= w_busy_nxt;
            o_drv_en       <= i_tx_en && (w_state_nxt != ST_FAULT);
            o_sfp_tx_dis_n <= i_tx_en && (w_state_nxt != ST_FAULT);
        end
    end

    // ------------------------------------------------------------------------
    // LED stretchers
    // ------------------------------------------------------------------------
    // Frame-activity LED: reload on each snapshot, then count down.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_led_act_cnt <= '0;
        end else if (w_snap) begin
            r_led_act_cnt <= c_LED_LOAD;
        end else if (r_led_act_cnt != '0) begin
            r_led_act_cnt <= r_led_act_cnt - c_LED_ONE;
        end
    end

    // Fault LED: reload on each entry into FAULT, then count down.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_led_flt_cnt <= '0;
        end else if (w_fault_entry) begin
            r_led_flt_cnt <= c_LED_LOAD;
        end else if (r_led_flt_cnt != '0) begin
            r_led_flt_cnt <= r_led_flt_cnt - c_LED_ONE;
        end
    end

    assign o_tx_led = {(r_led_flt_cnt != '0), (r_led_act_cnt != '0)};

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx_framer
//  Purpose  : Self-checking bench for serial_tx_framer (2 x 16-bit words,
//             4 clocks per bit, 4 gap bits, short LED stretch).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_tx_framer;

    localparam int LED_STRETCH = 20;
    localparam int HIST_N      = 16384;

    logic        clk;
    logic        rst;
    logic        tx_en;
    logic        flt;
    logic [31:0] tx_data;
    logic        o_serial;
    logic        o_drv_en;
    logic        o_sfp_tx_dis_n;
    logic        o_frame_start;
    logic        o_busy;
    logic [3:0]  o_seq;
    logic [1:0]  o_tx_led;

    serial_tx_framer #(
        .N_CH        (2),
        .DATA_W      (16),
        .BIT_CLKS    (4),
        .GAP_BITS    (4),
        .SYNC_PAT    (8'hAB),
        .LED_STRETCH (LED_STRETCH)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_tx_en        (tx_en),
        .i_sfp_tx_flt   (flt),
        .i_tx_data      (tx_data),
        .o_serial       (o_serial),
        .o_drv_en       (o_drv_en),
        .o_sfp_tx_dis_n (o_sfp_tx_dis_n),
        .o_frame_start  (o_frame_start),
        .o_busy         (o_busy),
        .o_seq          (o_seq),
        .o_tx_led       (o_tx_led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // History of outputs sampled on every falling edge:
    // [4] serial, [3] busy, [2] fault LED, [1] activity LED, [0] drv_en
    logic [4:0] hist [0:HIST_N-1];
    int         cyc = 0;
    int         fs_cyc[$];

    always @(negedge clk) begin
        if (cyc < HIST_N) hist[cyc] = {o_serial, o_busy, o_tx_led[1], o_tx_led[0], o_drv_en};
        if (o_frame_start) fs_cyc.push_back(cyc);
        cyc = cyc + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] d0;
        logic [15:0] d1;
        logic [7:0]  crc;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int idx);
        while (cyc <= idx) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_fs(input int want, input int budget, input string name, output int c);
        int n;
        n = 0;
        c = -1;
        while ((fs_cyc.size() < want) && (n < budget)) begin
            step();
            n++;
        end
        if (fs_cyc.size() >= want) begin
            c = fs_cyc[want-1];
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s frame_start not seen within %0d clocks", name, budget);
        end
    endtask

    // Line bit k of a frame starting (frame_start) at sample c occupies
    // samples c+1+4k .. c+4+4k.
    task automatic decode(input int c, output logic [59:0] bits, output logic cell_ok);
        logic v;
        cell_ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            v = hist[c + 1 + 4*k][4];
            bits[59-k] = v;
            for (int j = 1; j < 4; j++) begin
                if (hist[c + 1 + 4*k + j][4] !== v) cell_ok = 1'b0;
            end
        end
    endtask

    function automatic logic [7:0] crc8_model(input logic [39:0] msg);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 39; i >= 0; i--) begin
            if (c[7] ^ msg[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else               c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [59:0] exp_frame(input logic [3:0] seq, input logic [15:0] d0,
                                              input logic [15:0] d1, input logic [7:0] crc);
        return {8'hAB, seq, 4'b0000, d0, d1, crc, 4'hF};
    endfunction

    task automatic check_frame(input string name, input int c, input logic [59:0] exp);
        logic [59:0] bits;
        logic        ok;
        decode(c, bits, ok);
        check({name, "_bits"}, bits, exp);
        check({name, "_cells"}, ok, 1'b1);
    endtask

    initial begin
        int          c;
        int          c2;
        int          r;
        int          n0;
        logic        ok;
        logic [15:0] d0;
        logic [15:0] d1;
        int          fsc [17];

        vecs[0] = '{16'h0001, 16'h0000, 8'h6B};
        vecs[1] = '{16'h0000, 16'h0000, 8'h00};
        vecs[2] = '{16'h0000, 16'h0001, 8'h07};
        vecs[3] = '{16'h0000, 16'h0100, 8'h15};
        vecs[4] = '{16'h8000, 16'h0000, 8'h31};

        rst     = 1'b1;
        tx_en   = 1'b0;
        flt     = 1'b0;
        tx_data = 32'h0;
        step();
        step();
        check("reset_outputs",
              {o_serial, o_drv_en, o_sfp_tx_dis_n, o_frame_start, o_busy, o_seq, o_tx_led},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0});
        rst = 1'b0;
        step();

        // Table of single frames, each the first after reset (header 0x00).
        for (int v = 0; v < 5; v++) begin
            do_reset();
            tx_data = {vecs[v].d1, vecs[v].d0};
            tx_en   = 1'b1;
            n0      = fs_cyc.size();
            wait_fs(n0 + 1, 50, $sformatf("vec%0d_start", v), c);
            tx_en   = 1'b0;
            if (c >= 0) begin
                check($sformatf("vec%0d_seq", v), o_seq, 4'd0);
                wait_until(c + 260);
                check_frame($sformatf("vec%0d", v), c,
                            exp_frame(4'd0, vecs[v].d0, vecs[v].d1, vecs[v].crc));
                check($sformatf("vec%0d_single", v), fs_cyc.size(), n0 + 1);
                check($sformatf("vec%0d_idle_busy", v), hist[c + 250][3], 1'b0);
            end
        end

        // 17 back-to-back frames: sequence wrap and exact frame period.
        do_reset();
        d0      = 16'h0001;
        d1      = 16'h0000;
        tx_data = {d1, d0};
        tx_en   = 1'b1;
        n0      = fs_cyc.size();
        for (int f = 0; f < 17; f++) begin
            wait_fs(n0 + f + 1, 300, $sformatf("b2b%0d_start", f), fsc[f]);
        end
        tx_en = 1'b0;
        if (fsc[16] >= 0) begin
            wait_until(fsc[16] + 260);
            for (int f = 0; f < 17; f++) begin
                check_frame($sformatf("b2b%0d", f), fsc[f],
                            exp_frame(4'(f), d0, d1, crc8_model({4'(f), 4'b0000, d0, d1})));
                if (f > 0) check($sformatf("b2b%0d_period", f), fsc[f] - fsc[f-1], 240);
            end
            check("b2b_stop", fs_cyc.size(), n0 + 17);
        end

        // Drop enable at clock 100 of a frame.
        do_reset();
        d0      = 16'h1234;
        d1      = 16'hABCD;
        tx_data = {d1, d0};
        tx_en   = 1'b1;
        n0      = fs_cyc.size();
        wait_fs(n0 + 1, 50, "drop_start", c);
        if (c >= 0) begin
            wait_until(c + 100);
            tx_en = 1'b0;
            check("drop_drv_hold", {o_drv_en, o_sfp_tx_dis_n}, 2'b11);
            step();
            check("drop_drv_fall", {o_drv_en, o_sfp_tx_dis_n}, 2'b00);
            wait_until(c + 262);
            check_frame("drop", c, exp_frame(4'd0, d0, d1, crc8_model({8'h00, d0, d1})));
            check("drop_busy_end", {hist[c + 239][3], hist[c + 240][3]}, 2'b10);
            check("drop_led_act", {hist[c][1], hist[c + 19][1], hist[c + 20][1]}, 3'b110);
            check("drop_no_restart", fs_cyc.size(), n0 + 1);
        end

        // SFP fault at clock 50 of a frame, then release and recovery.
        do_reset();
        d0      = 16'hA5C3;
        d1      = 16'h0F1E;
        tx_data = {d1, d0};
        tx_en   = 1'b1;
        n0      = fs_cyc.size();
        wait_fs(n0 + 1, 50, "flt_start", c);
        if (c >= 0) begin
            wait_until(c + 50);
            flt = 1'b1;
            wait_until(c + 53);
            check("flt_latency_busy", {hist[c + 52][3], hist[c + 53][3]}, 2'b10);
            check("flt_entry", {o_serial, o_tx_led[1], o_drv_en, o_sfp_tx_dis_n}, 4'b1100);
            wait_until(c + 70);
            ok = 1'b1;
            for (int i = c + 53; i <= c + 70; i++) begin
                if (hist[i][4] !== 1'b1 || hist[i][3] !== 1'b0) ok = 1'b0;
            end
            check("flt_line_idle", ok, 1'b1);
            r   = cyc - 1;
            flt = 1'b0;
            wait_fs(n0 + 2, 60, "flt_restart", c2);
            if (c2 >= 0) begin
                check("flt_restart_min", (c2 - r) >= 18, 1'b1);
                check("flt_restart_max", (c2 - r) <= 24, 1'b1);
                check("flt_led_flt", {hist[c + 72][2], hist[c + 73][2]}, 2'b10);
                check("flt_seq", o_seq, 4'd1);
                tx_en = 1'b0;
                wait_until(c2 + 250);
                check_frame("flt_recover", c2,
                            exp_frame(4'd1, d0, d1, crc8_model({8'h10, d0, d1})));
            end
        end

        // Reset mid-DATA of the second frame; the next frame restarts at seq 0.
        do_reset();
        d0      = 16'hFFFF;
        d1      = 16'h0000;
        tx_data = {d1, d0};
        tx_en   = 1'b1;
        n0      = fs_cyc.size();
        wait_fs(n0 + 2, 300, "rst_start", c);
        if (c >= 0) begin
            wait_until(c + 100);
            check("rst_seq_before", o_seq, 4'd1);
            rst = 1'b1;
            #1;
            check("rst_async_outputs",
                  {o_serial, o_drv_en, o_sfp_tx_dis_n, o_frame_start, o_busy, o_seq, o_tx_led},
                  {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0});
            step();
            step();
            rst = 1'b0;
            n0  = fs_cyc.size();
            wait_fs(n0 + 1, 50, "rst_restart", c2);
            tx_en = 1'b0;
            if (c2 >= 0) begin
                check("rst_seq_after", o_seq, 4'd0);
                wait_until(c2 + 250);
                check_frame("rst_frame", c2, exp_frame(4'd0, d0, d1, crc8_model({8'h00, d0, d1})));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
